// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch stage sitting behind the PC register. It issues fetch
//   requests for pc_i to instruction memory and matches the in-order
//   responses against the request addresses. Responses are buffered in a
//   small FIFO, and the FIFO head is presented to the IF/ID register. A jump
//   discards all buffered and in-flight work: responses that are still
//   outstanding at the jump are counted in drop_cnt and thrown away when they
//   arrive.
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   pc_i            current PC (becomes imem_addr_o)
//   jump_flag_i     redirect: flush everything this edge
//   hold_flag_i     pipeline hold level; >= HOLD_IF freezes the output
//   pc_stall_o      PC register must hold pc_i this cycle
//   imem_req_o/imem_addr_o/imem_gnt_i          request channel
//   imem_rvalid_i/imem_rdata_i                 in-order response channel
//   inst_o/inst_addr_o/inst_valid_o            output to IF/ID
module if_fetch_unit #(
    parameter int                 FIFO_DEPTH = 2,
    parameter int                 MAX_OUTST  = 2,
    parameter int                 HOLD_W     = 3,
    parameter logic [HOLD_W-1:0]  HOLD_IF    = HOLD_W'(2),
    parameter logic [31:0]        NOP_INST   = 32'h13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       pc_i,
    input  logic              jump_flag_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    output logic              pc_stall_o,
    output logic              imem_req_o,
    output logic [31:0]       imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       inst_o,
    output logic [31:0]       inst_addr_o,
    output logic              inst_valid_o
);
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int AQ_W   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t             state;
    // outst_cnt counts every request in flight, including stale ones that
    // drop_cnt says must be discarded when they come back.
    logic [CNT_W-1:0]   outst_cnt, outst_next;
    logic [CNT_W-1:0]   drop_cnt, drop_next;

    logic [31:0]        aq_mem [MAX_OUTST];
    logic [AQ_W-1:0]    aq_wr, aq_rd;

    logic [31:0]        fifo_inst [FIFO_DEPTH];
    logic [31:0]        fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]  fifo_cnt;

    logic accept, keep_rsp, consume;

    // The address queue depth need not be a power of two, so wrap explicitly.
    function automatic logic [AQ_W-1:0] aq_inc(input logic [AQ_W-1:0] p);
        if (int'(p) == MAX_OUTST - 1)
            return '0;
        else
            return p + AQ_W'(1);
    endfunction

    // Issue only when the response is guaranteed a FIFO slot.
    always_comb begin
        imem_req_o  = !rst_i && !jump_flag_i
                      && (int'(outst_cnt) < MAX_OUTST)
                      && ((int'(outst_cnt) + int'(fifo_cnt)) < FIFO_DEPTH);
        imem_addr_o = pc_i;
        pc_stall_o  = !(imem_req_o && imem_gnt_i) && !jump_flag_i;
    end

    assign accept   = imem_req_o && imem_gnt_i;
    // In DRAIN the oldest in-flight responses are stale and arrive first.
    assign keep_rsp = imem_rvalid_i && (state == RUN) && !jump_flag_i;
    assign consume  = inst_valid_o && (hold_flag_i < HOLD_IF) && !jump_flag_i;

    always_comb begin
        outst_next = outst_cnt;
        drop_next  = drop_cnt;
        if (jump_flag_i) begin
            // Everything still in flight after this edge is stale.
            drop_next  = outst_cnt - CNT_W'(imem_rvalid_i);
            outst_next = drop_next;
        end else begin
            outst_next = outst_cnt + CNT_W'(accept) - CNT_W'(imem_rvalid_i);
            if (imem_rvalid_i && (state == DRAIN))
                drop_next = drop_cnt - CNT_W'(1);
        end
    end

    // Control state: counters, pointers, drop FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            outst_cnt <= '0;
            drop_cnt  <= '0;
            aq_wr     <= '0;
            aq_rd     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            outst_cnt <= outst_next;
            drop_cnt  <= drop_next;
            state     <= (drop_next != '0) ? DRAIN : RUN;
            if (jump_flag_i) begin
                aq_wr    <= '0;
                aq_rd    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (accept)
                    aq_wr <= aq_inc(aq_wr);
                if (keep_rsp) begin
                    aq_rd  <= aq_inc(aq_rd);
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (consume)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                fifo_cnt <= fifo_cnt + FCNT_W'(keep_rsp) - FCNT_W'(consume);
            end
        end
    end

    // Storage: address queue and response FIFO payload
    always_ff @(posedge clk_i) begin
        if (accept)
            aq_mem[aq_wr] <= pc_i;
        if (keep_rsp) begin
            fifo_inst[wr_ptr] <= imem_rdata_i;
            fifo_addr[wr_ptr] <= aq_mem[aq_rd];
        end
    end

    // Output: FIFO head or NOP bubble
    always_comb begin
        inst_valid_o = (fifo_cnt != '0);
        inst_o       = inst_valid_o ? fifo_inst[rd_ptr] : NOP_INST;
        inst_addr_o  = inst_valid_o ? fifo_addr[rd_ptr] : 32'h0;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    localparam int          FIFO_DEPTH = 2;
    localparam int          MAX_OUTST  = 2;
    localparam int          HOLD_W     = 3;
    localparam logic [2:0]  HOLD_IF    = 3'd2;
    localparam logic [31:0] NOP        = 32'h13;

    logic        clk = 1'b0;
    logic        rst_i, jump_flag_i, imem_gnt_i, imem_rvalid_i;
    logic [2:0]  hold_flag_i;
    logic [31:0] pc_i, imem_rdata_i;
    logic        pc_stall_o, imem_req_o, inst_valid_o;
    logic [31:0] imem_addr_o, inst_o, inst_addr_o;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST), .HOLD_W(HOLD_W),
        .HOLD_IF(HOLD_IF), .NOP_INST(NOP)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i), .jump_flag_i(jump_flag_i),
        .hold_flag_i(hold_flag_i), .pc_stall_o(pc_stall_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
    );

    // Reference model: requests seen by memory (tagged stale after a jump)
    // and instructions expected to be presented, in order.
    typedef struct { logic [31:0] addr; bit stale; int rdy; } req_t;
    typedef struct { logic [31:0] inst; logic [31:0] addr; } ent_t;
    req_t mem_q[$];
    ent_t out_q[$];

    int checks = 0, errors = 0, cyc = 0;
    int rv_pct = 100, lat_max = 1, last_rdy = 0;
    logic [31:0] pc = 32'h0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, check combinational/registered outputs,
    // then advance the model with the values sampled at the posedge.
    task automatic step(input bit rst, input bit jump, input bit gnt,
                        input logic [2:0] hold, input logic [31:0] tgt);
        bit     rv;
        bit     exp_req;
        req_t   h;
        int     r;
        rv = 0;
        if (!rst && mem_q.size() > 0 && mem_q[0].rdy <= cyc
            && $urandom_range(99) < rv_pct)
            rv = 1;
        rst_i = rst; jump_flag_i = jump; imem_gnt_i = gnt; hold_flag_i = hold;
        pc_i = pc; imem_rvalid_i = rv;
        imem_rdata_i = rv ? mem_data(mem_q[0].addr) : $urandom;
        #1;
        exp_req = !rst && !jump && mem_q.size() < MAX_OUTST
                  && (mem_q.size() + out_q.size()) < FIFO_DEPTH;
        check("imem_req", imem_req_o, exp_req);
        check("pc_stall", pc_stall_o, !(exp_req && gnt) && !jump);
        check("imem_addr", imem_addr_o, pc);
        check("inst_valid", inst_valid_o, out_q.size() > 0);
        check("inst", inst_o, out_q.size() > 0 ? out_q[0].inst : NOP);
        check("inst_addr", inst_addr_o, out_q.size() > 0 ? out_q[0].addr : 32'h0);
        @(posedge clk);
        if (rst) begin
            mem_q.delete();
            out_q.delete();
        end else begin
            if (rv) h = mem_q.pop_front();
            if (jump) begin
                out_q.delete();
                foreach (mem_q[i]) mem_q[i].stale = 1;
            end else begin
                if (out_q.size() > 0 && hold < HOLD_IF) void'(out_q.pop_front());
                if (rv && !h.stale) out_q.push_back('{mem_data(h.addr), h.addr});
            end
            if (exp_req && gnt) begin
                r = cyc + $urandom_range(lat_max, 1);
                if (r < last_rdy) r = last_rdy;
                last_rdy = r;
                mem_q.push_back('{pc, 1'b0, r});
                pc = pc + 32'd4;
            end
        end
        if (jump) pc = tgt;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst_i = 1; jump_flag_i = 0; imem_gnt_i = 0; hold_flag_i = 0;
        pc_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        // first reset edge brings the DUT out of X; nothing to compare yet
        @(posedge clk);
        @(negedge clk);
        cyc = 0; last_rdy = 0;
        step(1, 0, 1, 0, 0);

        // streaming fetch, 1-cycle memory latency, no hold
        cyc = 0; last_rdy = 0; pc = 32'h0; rv_pct = 100; lat_max = 1;
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("first_valid", inst_valid_o, 1'b1);
        check("first_addr", inst_addr_o, 32'h0);
        repeat (12) step(0, 0, 1, 0, 0);

        // grant withheld: PC must stall, address held
        repeat (5) step(0, 0, 0, 0, 0);

        // hold at HOLD_IF freezes output, then release
        repeat (4) step(0, 0, 1, HOLD_IF, 0);
        repeat (8) step(0, 0, 1, 0, 0);

        // two requests in flight, then jump to 0x100 with no response that cycle
        rv_pct = 0;
        repeat (3) step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 32'h100);
        rv_pct = 100;
        repeat (3) step(0, 0, 1, 0, 0);
        check("post_jump_addr", inst_addr_o, 32'h100);
        repeat (6) step(0, 0, 1, 0, 0);

        // jump in the same cycle a live response arrives
        rv_pct = 0;
        repeat (3) step(0, 0, 1, 0, 0);
        rv_pct = 100;
        step(0, 1, 1, 0, 32'h200);
        repeat (8) step(0, 0, 1, 0, 0);

        // fill FIFO under hold, then reset mid-operation
        repeat (4) step(0, 0, 1, 3'd3, 0);
        step(1, 0, 1, 3'd3, 0);
        check("rst_valid", inst_valid_o, 1'b0);
        step(0, 0, 1, 0, 0);
        repeat (6) step(0, 0, 1, 0, 0);

        // randomized traffic
        rv_pct = 70; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 1), ($urandom_range(99) < 6),
                 ($urandom_range(99) < 75), 3'($urandom_range(3)),
                 {$urandom_range(255), 2'b00} + 32'h1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
